// File: rtl/mem_req_scheduler_pkg.sv
// Shared types and constants for the multi-core memory request scheduler.
package mem_req_scheduler_pkg;

  localparam int unsigned NUM_OF_CORES = 4;
  localparam int unsigned CoreIdW = (NUM_OF_CORES > 1) ? $clog2(NUM_OF_CORES) : 1;

  typedef struct packed {
    logic               vld;
    logic [CoreIdW-1:0] core_id;
    logic               we;
    logic [31:0]        addr;
    logic [31:0]        data;
  } request_t;

  // Stamp a request with the queue it entered through, whatever the core sent.
  function automatic request_t tag_req(input request_t req, input logic [CoreIdW-1:0] id);
    request_t r;
    r         = req;
    r.core_id = id;
    return r;
  endfunction

endpackage

// File: rtl/mem_req_scheduler_req_fifo.sv
// Per-core request queue: power-of-2 depth, registered occupancy, head visible combinationally.
module req_fifo
  import mem_req_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_push,
  input  request_t i_din,
  input  logic     i_pop,
  output request_t o_dout,
  output logic     o_full,
  output logic     o_empty
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [CntW-1:0]  r_count;
  request_t         r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// Round-robin arbiter over per-core request queues feeding one registered memory port,
// with a bounded count of requests awaiting response.
module mem_req_scheduler
  import mem_req_scheduler_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  request_t                             core_req [NUM_OF_CORES],
  output logic [NUM_OF_CORES-1:0]              core_req_rdy,
  output request_t                             mem_req,
  input  logic                                 mem_req_rdy,
  input  logic                                 mem_rsp_vld,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
  output logic                                 err_underflow
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_OF_CORES-1:0] w_full;
  logic [NUM_OF_CORES-1:0] w_empty;
  logic [NUM_OF_CORES-1:0] w_pop;
  request_t                w_head [NUM_OF_CORES];
  logic [CoreIdW-1:0]      r_rr_ptr;
  logic [CoreIdW-1:0]      w_winner;
  logic [CoreIdW-1:0]      w_idx;
  logic                    w_found;
  logic                    w_free;
  logic                    w_load;
  request_t                r_mem_req;
  logic [CntW-1:0]         r_cnt;
  logic                    r_err;

  for (genvar i = 0; i < NUM_OF_CORES; i++) begin : g_queue
    req_fifo #(
      .DEPTH(QUEUE_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .i_push (core_req[i].vld),
      .i_din  (tag_req(core_req[i], CoreIdW'(i))),
      .i_pop  (w_pop[i]),
      .o_dout (w_head[i]),
      .o_full (w_full[i]),
      .o_empty(w_empty[i])
    );
    assign w_pop[i] = w_load && (w_winner == CoreIdW'(i));
  end

  // First non-empty queue at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_OF_CORES; k++) begin
      w_idx = CoreIdW'((int'(r_rr_ptr) + k) % int'(NUM_OF_CORES));
      if (!w_found && !w_empty[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_free = !r_mem_req.vld || mem_req_rdy;
  assign w_load = w_free && w_found && (32'(r_cnt) < MAX_OUTSTANDING);

  assign core_req_rdy    = ~w_full;
  assign mem_req         = r_mem_req;
  assign outstanding_cnt = r_cnt;
  assign err_underflow   = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_req <= '0;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_load) begin
        r_mem_req <= w_head[w_winner];
        r_rr_ptr  <= CoreIdW'((int'(w_winner) + 1) % int'(NUM_OF_CORES));
      end else if (w_free) begin
        r_mem_req.vld <= 1'b0;
      end
      case ({w_load, mem_rsp_vld})
        2'b10: r_cnt <= r_cnt + 1'b1;
        2'b01: begin
          if (r_cnt == '0) r_err <= 1'b1;
          else             r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler with an in-order scoreboard of expected issues.
module tb_mem_req_scheduler;
  import mem_req_scheduler_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset;
  request_t                core_req [NUM_OF_CORES];
  logic [NUM_OF_CORES-1:0] core_req_rdy;
  request_t                mem_req;
  logic                    mem_req_rdy;
  logic                    mem_rsp_vld;
  logic [3:0]              outstanding_cnt;
  logic                    err_underflow;

  int       n_tests = 0;
  int       n_fail  = 0;
  request_t sb[$];

  always #5 clk = ~clk;

  mem_req_scheduler #(
    .QUEUE_DEPTH    (4),
    .MAX_OUTSTANDING(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .core_req       (core_req),
    .core_req_rdy   (core_req_rdy),
    .mem_req        (mem_req),
    .mem_req_rdy    (mem_req_rdy),
    .mem_rsp_vld    (mem_rsp_vld),
    .outstanding_cnt(outstanding_cnt),
    .err_underflow  (err_underflow)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < NUM_OF_CORES; i++) core_req[i] = '0;
  endtask

  // Drive a request with a wrong core_id; the expected issue carries the queue index.
  task automatic drive(input int core, input logic [31:0] addr);
    request_t r;
    r.vld     = 1'b1;
    r.core_id = CoreIdW'(NUM_OF_CORES - 1 - core);
    r.we      = addr[0];
    r.addr    = addr;
    r.data    = ~addr;
    core_req[core] = r;
    r.core_id = CoreIdW'(core);
    sb.push_back(r);
  endtask

  // Check any handshake about to complete, then advance one clock.
  task automatic cyc();
    request_t e;
    if (mem_req.vld && mem_req_rdy) begin
      if (sb.size() == 0) chk("sb_unexpected_issue", mem_req.vld, 1'b0);
      else begin
        e = sb.pop_front();
        chk("sb_issue", mem_req, e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (sb.size() > 0 && b > 0) begin
      cyc();
      b--;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic rsp(input int n);
    mem_rsp_vld = 1'b1;
    repeat (n) cyc();
    mem_rsp_vld = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    mem_req_rdy = 1'b0;
    mem_rsp_vld = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    sb.delete();
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    mem_req_rdy = 1'b0;
    mem_rsp_vld = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, '0);
    chk("rst_cnt", outstanding_cnt, 0);
    reset = 1'b1;
    chk("rst_rdy", core_req_rdy, 4'hF);
    chk("rst_err", err_underflow, 0);

    // Single request: two-cycle latency, core_id overwritten.
    mem_req_rdy = 1'b1;
    drive(0, 32'hA000_0010);
    cyc();
    idle();
    chk("a_no_bypass", mem_req.vld, 0);
    cyc();
    chk("a_vld", mem_req.vld, 1);
    chk("a_core_id", mem_req.core_id, 0);
    chk("a_cnt", outstanding_cnt, 1);
    cyc();
    chk("a_vld_clear", mem_req.vld, 0);
    rsp(1);
    chk("a_cnt_back", outstanding_cnt, 0);

    // All cores at once: issue order 0..3, pointer back at core 0.
    do_reset();
    mem_req_rdy = 1'b1;
    for (int c = 0; c < NUM_OF_CORES; c++) drive(c, 32'hB000_0000 + 32'(c * 16));
    cyc();
    idle();
    drain(10);
    chk("b_cnt4", outstanding_cnt, 4);
    drive(0, 32'hB100_0000);
    drive(1, 32'hB100_0011);
    cyc();
    idle();
    mem_rsp_vld = 1'b1;
    cyc();
    cyc();
    mem_rsp_vld = 1'b0;
    chk("b_cnt_coincide", outstanding_cnt, 4);
    drain(4);
    rsp(4);
    chk("b_cnt_zero", outstanding_cnt, 0);

    // Back-pressure: core 2 fills its queue while the output is held.
    mem_req_rdy = 1'b0;
    for (int p = 0; p < 5; p++) begin
      chk("c_rdy_before_push", core_req_rdy[2], 1);
      drive(2, 32'hC000_0000 + 32'(p));
      cyc();
    end
    idle();
    chk("c_rdy_full", core_req_rdy[2], 0);
    chk("c_hold", mem_req, sb[0]);
    cyc();
    chk("c_hold2", mem_req, sb[0]);
    chk("c_rdy_full2", core_req_rdy[2], 0);
    mem_req_rdy = 1'b1;
    cyc();
    chk("c_rdy_recover", core_req_rdy[2], 1);
    drain(10);
    chk("c_cnt5", outstanding_cnt, 5);
    rsp(5);
    chk("c_cnt_zero", outstanding_cnt, 0);

    // Outstanding limit: 8 issue, the 9th waits for a response.
    do_reset();
    mem_req_rdy = 1'b1;
    for (int c = 0; c < NUM_OF_CORES; c++) drive(c, 32'hD000_0000 + 32'(c));
    cyc();
    for (int c = 0; c < NUM_OF_CORES; c++) drive(c, 32'hD000_0100 + 32'(c));
    cyc();
    idle();
    drive(0, 32'hD000_0200);
    cyc();
    idle();
    repeat (7) cyc();
    chk("d_sb_left", sb.size(), 1);
    chk("d_cnt8", outstanding_cnt, 8);
    chk("d_no_9th", mem_req.vld, 0);
    cyc();
    chk("d_no_9th_b", mem_req.vld, 0);
    mem_rsp_vld = 1'b1;
    cyc();
    mem_rsp_vld = 1'b0;
    chk("d_no_load_same_cycle", mem_req.vld, 0);
    chk("d_cnt7", outstanding_cnt, 7);
    cyc();
    chk("d_9th_vld", mem_req.vld, 1);
    chk("d_9th_cnt", outstanding_cnt, 8);
    drain(4);
    rsp(8);
    chk("d_cnt_zero", outstanding_cnt, 0);

    // Response with nothing outstanding.
    mem_rsp_vld = 1'b1;
    cyc();
    mem_rsp_vld = 1'b0;
    chk("e_cnt_stays0", outstanding_cnt, 0);
    chk("e_err_set", err_underflow, 1);
    repeat (3) cyc();
    chk("e_err_sticky", err_underflow, 1);

    // Mid-operation reset discards everything.
    mem_req_rdy = 1'b0;
    for (int c = 0; c < NUM_OF_CORES; c++) drive(c, 32'hF000_0000 + 32'(c));
    cyc();
    idle();
    cyc();
    chk("f_vld_before", mem_req.vld, 1);
    #2 reset = 1'b0;
    #1;
    sb.delete();
    chk("f_mem_req", mem_req, '0);
    chk("f_cnt", outstanding_cnt, 0);
    chk("f_err", err_underflow, 0);
    chk("f_rdy", core_req_rdy, 4'hF);
    @(negedge clk);
    reset       = 1'b1;
    mem_req_rdy = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cyc();
      chk("f_no_issue", mem_req.vld, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1);
  end

endmodule
